bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that feeds the per-digit seven-segment hex decoders driving HEX0..HEX7. It takes a binary value (e.g. the switch bank or a CPU I/O register), produces DIGITS packed BCD nibbles, and presents them on a held output register with a start/busy/done handshake. Values that cannot be shown in DIGITS decimal digits saturate to all nines and raise an overflow flag.

## Interface
- W, default 27: binary input width; must satisfy 1 <= W <= 32.
- DIGITS, default 8: BCD digits produced; DIGITS=8 matches HEX0..HEX7.
- CLOCK_50  input  1  the single clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request conversion of `bin`; sampled only when `busy`=0.
- bin  input  W  unsigned binary value; sampled only on the edge that accepts `start`.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `bcd`/`overflow` take a new result.
- bcd  output  4*DIGITS  packed BCD; digit i in [4i+3:4i]; digit 0 is least significant, for HEX0.
- overflow  output  1  last result exceeded 10^DIGITS - 1.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE or DONE, start=1:
  - load shift register with `bin`;
  - clear scratch digit register (4*DIGITS bits) and latch the overflow compare (`bin` > 10^DIGITS - 1, unsigned);
  - set iteration counter to W and go to SHIFT.
- IDLE or DONE, start=0: go to / stay in IDLE.
- SHIFT iteration, one per edge:
  - each scratch digit >= 5 gets +3 (4-bit add, no carry between digits);
  - shift {scratch, shift reg} left by 1;
  - decrement counter.
- Final SHIFT iteration (counter 1 -> 0):
  - write result to `bcd` and the latched compare to `overflow`;
  - enter DONE.
- Overflow: if the latched compare=1, `bcd` is written as all 4'h9 instead of the scratch value.
- DONE lasts exactly one cycle; `done`=1 only in DONE.
- `start` while busy=1 is ignored, not queued; `bin` changes during SHIFT have no effect.
- Every scratch digit is always <= 9, and `bcd` never holds a nibble > 9.

## Timing
- Reset values: busy=0, done=0, bcd=0, overflow=0, state IDLE, counter 0.
- Start accepted at edge 0 -> busy=1 from cycle 1 through cycle W (W cycles).
- done=1 and new `bcd` visible in cycle W+1 (after edge W); busy=0 in that cycle.
- Latency from the accepting edge to done: W edges (27 at default).
- Back-to-back: start=1 during the done cycle is accepted, so throughput is one result per W+1 cycles.
- `bcd`/`overflow` hold their value until the next done cycle. They are never partially updated and never cleared except by rst.
- rst=1 mid-conversion: on that edge return to IDLE with all outputs at reset values; no done pulse for the aborted conversion.
- rst has priority over start on the same edge.
- W=1 edge case: single SHIFT cycle; done in cycle 2.

## Test plan
- Reset, then start with bin=0 -> done in cycle 28 after the accepting edge; bcd=32'h00000000, overflow=0; busy high exactly 27 cycles.
- bin=12345678 -> bcd=32'h12345678, overflow=0. Then bin=0x3FFFF (18-bit switch max, 262143) -> bcd=32'h00262143.
- bin=99999999 -> bcd=32'h99999999, overflow=0. Then bin=100000000 -> bcd=32'h99999999, overflow=1. Then bin=134217727 (2^27-1) -> same saturated result.
- Start bin=42; pulse start with bin=7 at cycle 5 while busy -> single done, bcd=32'h00000042; bin changed mid-conversion has no effect.
- Start bin=500, assert start with bin=77 in the done cycle -> first done bcd=32'h00000500, second done exactly 28 cycles later with bcd=32'h00000077.
- After a result 32'h00001234, start bin=9999, assert rst at cycle 10 -> next cycle busy=0, done=0, bcd=0, overflow=0; no done pulse follows; a fresh start converts normally.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus between a binary source and the
// shift-and-add-3 BCD converter.
interface bin2bcd_seq_if #(
  parameter int W      = 27,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [W-1:0]          bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a
// held, saturating result register for the HEX digit decoders.
module bin2bcd_seq #(
  parameter int W      = 27,
  parameter int DIGITS = 8
) (
  input  logic          CLOCK_50,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest representable value; ten or more digits always hold a 32-bit input.
  function automatic logic [63:0] max_value();
    logic [63:0] p;
    p = 64'd1;
    if (DIGITS >= 10) begin
      return 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        p = p * 64'd10;
      end
      return p - 64'd1;
    end
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] all_nines();
    logic [BW-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'h9;
    end
    return r;
  endfunction

  localparam logic [63:0]   MAX_VAL = max_value();
  localparam logic [BW-1:0] NINES   = all_nines();

  state_e            state_q, state_d;
  logic [W-1:0]      sh_q, sh_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_lat_q, ovf_lat_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     scr_adj;
  logic [BW-1:0]     scr_next;

  // Next-state logic: accept in IDLE/DONE, one add-3 + shift step per SHIFT cycle.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    scr_d     = scr_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    scr_adj   = add3(scr_q);
    scr_next  = {scr_adj[BW-2:0], sh_q[W-1]};
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          sh_d      = bus.bin;
          scr_d     = {BW{1'b0}};
          ovf_lat_d = (64'(bus.bin) > MAX_VAL);
          cnt_d     = CNT_W'(W);
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        scr_d = scr_next;
        sh_d  = sh_q << 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bcd_d   = ovf_lat_q ? NINES : scr_next;
          ovf_d   = ovf_lat_q;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_q      <= {W{1'b0}};
      scr_q     <= {BW{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      ovf_lat_q <= 1'b0;
      bcd_q     <= {BW{1'b0}};
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      scr_q     <= scr_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized bench for bin2bcd_seq: a cycle-count/arithmetic model is compared
// every cycle, plus directed conversions against literal BCD values.
module tb_bin2bcd_seq;

  localparam int W      = 27;
  localparam int DIGITS = 8;
  localparam int BW     = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.W(W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: cycles left in the conversion, captured value, held result.
  int            m_rem  = 0;
  logic [W-1:0]  m_val  = '0;
  logic [BW-1:0] m_bcd  = '0;
  logic          m_ovf  = 1'b0;
  logic          m_done = 1'b0;

  function automatic longint unsigned limit();
    longint unsigned lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    return lim;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v);
    return v >= limit();
  endfunction

  function automatic logic [BW-1:0] ref_bcd(input longint unsigned v);
    logic [BW-1:0] r = '0;
    longint unsigned x = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (ref_ovf(v)) begin
        r[4*i +: 4] = 4'h9;
      end else begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_rem  <= 0;
      m_bcd  <= '0;
      m_ovf  <= 1'b0;
      m_done <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) begin
        m_bcd <= ref_bcd(longint'(m_val));
        m_ovf <= ref_ovf(longint'(m_val));
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_rem <= W;
        m_val <= bus.bin;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.busy, (m_rem > 0));
      check("done", bus.done, m_done);
      check("bcd", bus.bcd, m_bcd);
      check("overflow", bus.overflow, m_ovf);
    end
  end

  // Called at a negedge; drives start, then measures latency and busy length.
  task automatic run(input logic [W-1:0] v, input logic [BW-1:0] exp, input logic exp_ovf,
                     input int glitch, input string name);
    int  n   = 0;
    int  nb  = 0;
    bit  got = 1'b0;
    bus.start = 1'b1;
    bus.bin   = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin   = W'($urandom);
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk);
      if (i == glitch) begin
        bus.start = 1'b1;
        bus.bin   = W'(7);
      end else if (i == glitch + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy) nb++;
      if (bus.done) begin
        got = 1'b1;
        n   = i;
      end
    end
    check({name, "_latency"}, n, W + 1);
    check({name, "_busy_cycles"}, nb, W);
    check({name, "_bcd"}, bus.bcd, exp);
    check({name, "_ovf"}, bus.overflow, exp_ovf);
  endtask

  task automatic count_done(input int cycles, input string name);
    int nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check(name, nd, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_bcd", bus.bcd, 32'h0000_0000);
    check("rst_ovf", bus.overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run(27'd0, 32'h0000_0000, 1'b0, 0, "zero");
    repeat (2) @(negedge clk);
    run(27'd12345678, 32'h1234_5678, 1'b0, 0, "d12345678");
    repeat (1) @(negedge clk);
    run(27'h3FFFF, 32'h0026_2143, 1'b0, 0, "sw_max");
    run(27'd99999999, 32'h9999_9999, 1'b0, 0, "nines");
    run(27'd100000000, 32'h9999_9999, 1'b1, 0, "ovf_lo");
    run(27'd134217727, 32'h9999_9999, 1'b1, 0, "ovf_max");
    repeat (2) @(negedge clk);

    run(27'd42, 32'h0000_0042, 1'b0, 5, "busy_start");
    count_done(35, "no_extra_done");

    run(27'd500, 32'h0000_0500, 1'b0, 0, "b2b_first");
    run(27'd77, 32'h0000_0077, 1'b0, 0, "b2b_second");
    repeat (2) @(negedge clk);

    run(27'd1234, 32'h0000_1234, 1'b0, 0, "pre_abort");
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 27'd9999;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_bcd", bus.bcd, 32'h0000_0000);
    check("abort_ovf", bus.overflow, 1'b0);
    rst = 1'b0;
    count_done(40, "abort_no_done");
    run(27'd2024, 32'h0000_2024, 1'b0, 0, "after_abort");

    for (int k = 0; k < 25; k++) begin
      logic [W-1:0] v;
      int mode = $urandom_range(0, 3);
      if (mode == 0)      v = W'($urandom_range(0, 999));
      else if (mode == 1) v = W'($urandom_range(99999990, 100000010));
      else                v = W'($urandom);
      run(v, ref_bcd(longint'(v)), ref_ovf(longint'(v)), (mode == 3) ? 11 : 0, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
